bus_keeper_n: RTL and testbench

- Parametrised successor to the LC-3 datapath bus multiplexer.
- Drives one WIDTH-bit shared bus from NSRC tri-state-style sources, each with its own gate enable.
- Adds a bus keeper (holds the last driven value while undriven), deterministic priority resolution of multi-gate conflicts, sticky error reporting, a saturating conflict counter and an optional output register stage.
- Sits between the datapath source units (MARMUX, PC, ALU, MDR, plus future sources) and all bus loads (IR, MAR, MDR, register file, PC).

---
 rtl/bus_pkg.sv | 21 ++
 rtl/prio_onehot_enc.sv | 25 ++
 rtl/bus_keeper_n.sv | 102 ++++++++++
 tb/tb_bus_keeper_n.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the LC-3 style bus keeper: default sizes, the
// source index map and the conflict-detection helper.
package bus_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_NSRC  = 4;

    typedef enum logic [1:0] {
        SRC_MARMUX = 2'd0,
        SRC_PC     = 2'd1,
        SRC_ALU    = 2'd2,
        SRC_MDR    = 2'd3
    } lc3_src_e;

    // True when two or more bits are set. Clearing the lowest set bit leaves
    // a non-zero value only if another bit is set. Callers zero-extend to 32.
    function automatic logic popcount_ge2(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/prio_onehot_enc.sv
// Priority encoder: the lowest-index asserted request wins. It also flags
// whether any request is asserted and whether more than one is asserted.
module prio_onehot_enc
    import bus_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    always_comb begin
        idx = '0;
        // Walk from high to low so that the lowest asserted index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
        any   = |req;
        multi = popcount_ge2(32'(req));
    end

endmodule

// File: rtl/bus_keeper_n.sv
// Shared datapath bus with NSRC gated sources. It adds a keeper that holds the
// last driven value, priority conflict resolution and sticky conflict reporting.
module bus_keeper_n
    import bus_pkg::*;
#(
    parameter int                  WIDTH     = DEFAULT_WIDTH,
    parameter int                  NSRC      = DEFAULT_NSRC,
    parameter int                  REG_OUT   = 0,
    parameter int                  CNT_W     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    localparam int                 IW        = $clog2(NSRC)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       gate,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_driven,
    output logic [IW-1:0]         drv_idx,
    output logic                  conflict,
    output logic                  conflict_sticky,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IW-1:0]    win;
    logic             any_gate;
    logic             multi_gate;
    logic [WIDTH-1:0] keeper;
    logic [WIDTH-1:0] resolved;

    prio_onehot_enc #(.N(NSRC)) u_enc (
        .req   (gate),
        .idx   (win),
        .any   (any_gate),
        .multi (multi_gate)
    );

    always_comb begin
        resolved = keeper;
        for (int i = 0; i < NSRC; i++) begin
            if (any_gate && win == IW'(i)) resolved = src_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keeper <= RESET_VAL;
        end else if (any_gate) begin
            keeper <= resolved;
        end
    end

    // A conflict in the same cycle as clr_err restarts the count at one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end else if (multi_gate) begin
            conflict_sticky <= 1'b1;
            if (clr_err)                    conflict_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
        end else if (clr_err) begin
            conflict_sticky <= 1'b0;
            conflict_cnt    <= '0;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic          driven_q;
            logic [IW-1:0] idx_q;
            logic          conf_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    driven_q <= 1'b0;
                    idx_q    <= '0;
                    conf_q   <= 1'b0;
                end else begin
                    driven_q <= any_gate;
                    idx_q    <= win;
                    conf_q   <= multi_gate;
                end
            end

            // The keeper doubles as the output register.
            assign bus_out    = keeper;
            assign bus_driven = driven_q;
            assign drv_idx    = idx_q;
            assign conflict   = conf_q;
        end else begin : g_comb
            assign bus_out    = resolved;
            assign bus_driven = any_gate;
            assign drv_idx    = win;
            assign conflict   = multi_gate;
        end
    endgenerate

endmodule

// File: tb/tb_bus_keeper_n.sv
// Bench for bus_keeper_n: a combinational-output instance and a registered-output
// instance share all inputs and are checked against a small reference model.
module tb_bus_keeper_n;
    import bus_pkg::*;

    localparam int W = 16;
    localparam int N = 4;
    localparam int C = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N*W-1:0] src_data;
    logic [N-1:0] gate;
    logic         clr_err;

    logic [W-1:0] bus_out,    bus_out_r;
    logic         bus_driven, bus_driven_r;
    logic [1:0]   drv_idx,    drv_idx_r;
    logic         conflict,   conflict_r;
    logic         sticky,     sticky_r;
    logic [C-1:0] cnt,        cnt_r;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 Clk = ~Clk;

    bus_keeper_n #(.WIDTH(W), .NSRC(N), .REG_OUT(0), .CNT_W(C), .RESET_VAL(16'h0000)) dut (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clr_err(clr_err),
        .bus_out(bus_out), .bus_driven(bus_driven), .drv_idx(drv_idx), .conflict(conflict),
        .conflict_sticky(sticky), .conflict_cnt(cnt)
    );

    bus_keeper_n #(.WIDTH(W), .NSRC(N), .REG_OUT(1), .CNT_W(C), .RESET_VAL(16'h0000)) dut_r (
        .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clr_err(clr_err),
        .bus_out(bus_out_r), .bus_driven(bus_driven_r), .drv_idx(drv_idx_r), .conflict(conflict_r),
        .conflict_sticky(sticky_r), .conflict_cnt(cnt_r)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; gate = '0; clr_err = 1'b0; src_data = '0;
        tick(); tick();
        Reset = 1'b0; #1;
        n_checks++; if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_bus got=%h exp=0000", bus_out); end
        n_checks++; if (bus_driven !== 1'b0) begin n_fail++; $display("FAIL reset_driven got=%b exp=0", bus_driven); end
        n_checks++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        n_checks++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got=%b exp=0", sticky); end
        n_checks++; if (bus_out_r !== 16'h0000 || bus_driven_r !== 1'b0) begin
            n_fail++; $display("FAIL reset_reg got=%h/%b exp=0000/0", bus_out_r, bus_driven_r); end
    endtask

    task automatic test_keeper_hold();
        src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        gate = 4'b0100; exp_q.push_back(16'h3333); #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (bus_out !== exp_v) begin n_fail++; $display("FAIL single_bus got=%h exp=%h", bus_out, exp_v); end
        n_checks++; if (drv_idx !== SRC_ALU) begin n_fail++; $display("FAIL single_idx got=%0d exp=2", drv_idx); end
        n_checks++; if (bus_driven !== 1'b1 || conflict !== 1'b0) begin
            n_fail++; $display("FAIL single_flags got=%b/%b exp=1/0", bus_driven, conflict); end
        tick();
        gate = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'h3333); #1;
            exp_v = exp_q.pop_front();
            n_checks++; if (bus_out !== exp_v) begin n_fail++; $display("FAIL hold_bus cyc=%0d got=%h exp=%h", k, bus_out, exp_v); end
            n_checks++; if (bus_driven !== 1'b0 || drv_idx !== 2'd0) begin
                n_fail++; $display("FAIL hold_flags cyc=%0d got=%b/%0d exp=0/0", k, bus_driven, drv_idx); end
            tick();
        end
    endtask

    task automatic test_conflict();
        gate = 4'b1010; exp_q.push_back(16'h2222); #1;
        exp_v = exp_q.pop_front();
        n_checks++; if (bus_out !== exp_v) begin n_fail++; $display("FAIL conf_bus got=%h exp=%h", bus_out, exp_v); end
        n_checks++; if (drv_idx !== SRC_PC || conflict !== 1'b1) begin
            n_fail++; $display("FAIL conf_flags got=%0d/%b exp=1/1", drv_idx, conflict); end
        n_checks++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL conf_sticky_early got=%b exp=0", sticky); end
        tick();
        gate = 4'b0000; #1;
        n_checks++; if (sticky !== 1'b1 || cnt !== 4'd1) begin
            n_fail++; $display("FAIL conf_after got=%b/%0d exp=1/1", sticky, cnt); end
        n_checks++; if (bus_out !== 16'h2222) begin n_fail++; $display("FAIL conf_hold got=%h exp=2222", bus_out); end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        exp_cnt = 1;
        gate = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            n_checks++; if (cnt !== 4'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", k, cnt, exp_cnt); end
        end
        gate = 4'b0000; clr_err = 1'b1;
        tick();
        clr_err = 1'b0; #1;
        n_checks++; if (cnt !== 4'd0 || sticky !== 1'b0) begin
            n_fail++; $display("FAIL clr got=%0d/%b exp=0/0", cnt, sticky); end
    endtask

    task automatic test_clr_vs_conflict_and_reset();
        gate = 4'b0011; clr_err = 1'b1;
        tick();
        gate = 4'b0000; clr_err = 1'b0; #1;
        n_checks++; if (sticky !== 1'b1 || cnt !== 4'd1) begin
            n_fail++; $display("FAIL clr_vs_conf got=%b/%0d exp=1/1", sticky, cnt); end
        gate = 4'b0110; Reset = 1'b1; #1;
        n_checks++; if (bus_out !== 16'h2222) begin n_fail++; $display("FAIL reset_pass got=%h exp=2222", bus_out); end
        tick();
        Reset = 1'b0; gate = 4'b0000; #1;
        n_checks++; if (sticky !== 1'b0 || cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_conf got=%b/%0d exp=0/0", sticky, cnt); end
        n_checks++; if (bus_out !== 16'h0000 || bus_out_r !== 16'h0000) begin
            n_fail++; $display("FAIL reset_keeper got=%h/%h exp=0000/0000", bus_out, bus_out_r); end
        n_checks++; if (conflict_r !== 1'b0 || drv_idx_r !== 2'd0) begin
            n_fail++; $display("FAIL reset_reg_flags got=%b/%0d exp=0/0", conflict_r, drv_idx_r); end
    endtask

    task automatic test_reg_out();
        gate = 4'b0001; #1;
        n_checks++; if (bus_out_r !== 16'h0000 || bus_driven_r !== 1'b0) begin
            n_fail++; $display("FAIL regout_early got=%h/%b exp=0000/0", bus_out_r, bus_driven_r); end
        tick();
        gate = 4'b1100; #1;
        n_checks++; if (bus_out_r !== 16'h1111 || bus_driven_r !== 1'b1 || drv_idx_r !== 2'd0) begin
            n_fail++; $display("FAIL regout_late got=%h/%b/%0d exp=1111/1/0", bus_out_r, bus_driven_r, drv_idx_r); end
        tick();
        gate = 4'b0000; #1;
        n_checks++; if (bus_out_r !== 16'h3333 || drv_idx_r !== 2'd2 || conflict_r !== 1'b1) begin
            n_fail++; $display("FAIL regout_conf got=%h/%0d/%b exp=3333/2/1", bus_out_r, drv_idx_r, conflict_r); end
        tick();
        n_checks++; if (bus_out_r !== 16'h3333 || bus_driven_r !== 1'b0) begin
            n_fail++; $display("FAIL regout_hold got=%h/%b exp=3333/0", bus_out_r, bus_driven_r); end
    endtask

    // Random back-to-back traffic; the registered instance's expectation waits
    // one cycle in the queue.
    task automatic test_back_to_back();
        logic [W-1:0] m_keep;
        logic [W-1:0] res;
        int           m_cnt;
        logic         m_sticky;
        logic         multi;
        Reset = 1'b1; gate = '0; clr_err = 1'b0;
        tick();
        Reset = 1'b0;
        m_keep = '0; m_cnt = 0; m_sticky = 1'b0;
        for (int k = 0; k < 60; k++) begin
            for (int s = 0; s < N; s++) src_data[s*W +: W] = W'($urandom_range(0, 65535));
            gate    = N'($urandom_range(0, 15));
            clr_err = ($urandom_range(0, 5) == 0);
            res = m_keep;
            for (int s = N - 1; s >= 0; s--) if (gate[s]) res = src_data[s*W +: W];
            multi = popcount_ge2(32'(gate));
            #1;
            n_checks++; if (bus_out !== res || conflict !== multi) begin
                n_fail++; $display("FAIL b2b_comb cyc=%0d got=%h/%b exp=%h/%b", k, bus_out, conflict, res, multi); end
            exp_q.push_back(res);
            tick();
            if (gate != '0) m_keep = res;
            if (multi) begin
                m_sticky = 1'b1;
                m_cnt = clr_err ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
            end else if (clr_err) begin
                m_sticky = 1'b0; m_cnt = 0;
            end
            exp_v = exp_q.pop_front();
            n_checks++; if (bus_out_r !== exp_v) begin n_fail++; $display("FAIL b2b_reg cyc=%0d got=%h exp=%h", k, bus_out_r, exp_v); end
            n_checks++; if (cnt !== 4'(m_cnt) || sticky !== m_sticky) begin
                n_fail++; $display("FAIL b2b_err cyc=%0d got=%0d/%b exp=%0d/%b", k, cnt, sticky, m_cnt, m_sticky); end
        end
        gate = '0; clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_keeper_hold();
        test_conflict();
        test_saturation();
        test_clr_vs_conflict_and_reset();
        test_reg_out();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
